// File: rtl/dma_control.sv
// dma_control: single-channel DMA engine that moves a block of 32-bit words
// between an I/O peripheral and main memory. It requests the bus from the CPU,
// takes ownership of the memory-bus master mux while granted, moves one word
// at a time, then releases the bus and pulses done.
//
// Ports
//   clk, rst_n                  system clock (rising edge), async active-low reset
//   start, modo                 one-cycle start pulse; direction (0 = IO->mem, 1 = mem->IO)
//   dir_inicio, cuenta          first byte address and word count, latched on start
//   bus_req / bus_grant         bus handshake with the CPU
//   sel                         mux select, 1 while the DMA owns the bus
//   Datos_I_O, direccion_I_O    write data and address toward memory
//   MEM_RD_I_O, MEM_WR_I_O      memory strobes, held until mem_ack
//   mem_dato, mem_ack           memory read data and access completion
//   io_valid, io_dato_in, io_ready     peripheral -> DMA word handshake
//   io_dato_out, io_wr, io_accept      DMA -> peripheral word handshake
//   ocupado, done, err          busy flag, completion pulse, sticky grant-loss flag
//
// state   | meaning
// IDLE    | waiting for start
// REQ     | bus_req high, waiting for bus_grant
// IO_IN   | waiting for a word from the peripheral (modo=0)
// MEM_ACC | memory strobe active, waiting for mem_ack
// IO_OUT  | presenting a word to the peripheral (modo=1)
// RELEASE | one-cycle bus release, done pulse
module dma_control #(
    parameter int unsigned ADDR_STEP = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             modo,
    input  logic [31:0]      dir_inicio,
    input  logic [CNT_W-1:0] cuenta,
    output logic             bus_req,
    input  logic             bus_grant,
    output logic             sel,
    output logic [31:0]      Datos_I_O,
    output logic [31:0]      direccion_I_O,
    output logic             MEM_RD_I_O,
    output logic             MEM_WR_I_O,
    input  logic [31:0]      mem_dato,
    input  logic             mem_ack,
    input  logic             io_valid,
    input  logic [31:0]      io_dato_in,
    output logic             io_ready,
    output logic [31:0]      io_dato_out,
    output logic             io_wr,
    input  logic             io_accept,
    output logic             ocupado,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_IO_IN   = 3'd2;
    localparam logic [2:0] S_MEM_ACC = 3'd3;
    localparam logic [2:0] S_IO_OUT  = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    localparam logic [31:0]      STEP    = 32'(ADDR_STEP);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic             modo_q, modo_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    always_comb begin
        state_d = state_q;
        modo_d  = modo_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    modo_d  = modo;
                    addr_d  = dir_inicio;
                    rem_d   = cuenta;
                    err_d   = 1'b0;
                    state_d = (cuenta == '0) ? S_RELEASE : S_REQ;
                end
            end
            S_REQ: begin
                if (bus_grant) begin
                    state_d = modo_q ? S_MEM_ACC : S_IO_IN;
                end
            end
            S_IO_IN: begin
                // Grant loss takes priority over any handshake in the same cycle.
                if (!bus_grant) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else if (io_valid) begin
                    wdata_d = io_dato_in;
                    state_d = S_MEM_ACC;
                end
            end
            S_MEM_ACC: begin
                if (!bus_grant) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else if (mem_ack) begin
                    addr_d = addr_q + STEP;
                    rem_d  = rem_q - CNT_ONE;
                    if (modo_q) begin
                        rdata_d = mem_dato;
                        state_d = S_IO_OUT;
                    end else begin
                        // rem_q is the pre-decrement count, so 1 means last word.
                        state_d = (rem_q == CNT_ONE) ? S_RELEASE : S_IO_IN;
                    end
                end
            end
            S_IO_OUT: begin
                if (!bus_grant) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else if (io_accept) begin
                    state_d = (rem_q == '0) ? S_RELEASE : S_MEM_ACC;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            modo_q  <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            modo_q  <= modo_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode from the registered state, so they fall with the async reset.
    assign bus_req       = (state_q == S_REQ);
    assign sel           = (state_q == S_IO_IN) || (state_q == S_MEM_ACC) || (state_q == S_IO_OUT);
    assign MEM_WR_I_O    = (state_q == S_MEM_ACC) && !modo_q;
    assign MEM_RD_I_O    = (state_q == S_MEM_ACC) &&  modo_q;
    assign io_ready      = (state_q == S_IO_IN);
    assign io_wr         = (state_q == S_IO_OUT);
    assign ocupado       = (state_q != S_IDLE);
    assign done          = (state_q == S_RELEASE);
    assign err           = err_q;
    assign direccion_I_O = addr_q;
    assign Datos_I_O     = wdata_q;
    assign io_dato_out   = rdata_q;

endmodule

// File: tb/tb_dma_control.sv
module tb_dma_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        modo = 1'b0;
    logic [31:0] dir_inicio = '0;
    logic [15:0] cuenta = '0;
    logic        bus_req;
    logic        bus_grant = 1'b0;
    logic        sel;
    logic [31:0] Datos_I_O;
    logic [31:0] direccion_I_O;
    logic        MEM_RD_I_O;
    logic        MEM_WR_I_O;
    logic [31:0] mem_dato = '0;
    logic        mem_ack = 1'b0;
    logic        io_valid = 1'b0;
    logic [31:0] io_dato_in = '0;
    logic        io_ready;
    logic [31:0] io_dato_out;
    logic        io_wr;
    logic        io_accept = 1'b0;
    logic        ocupado;
    logic        done;
    logic        err;

    int total = 0;
    int bad = 0;

    dma_control #(.ADDR_STEP(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .modo(modo),
        .dir_inicio(dir_inicio), .cuenta(cuenta),
        .bus_req(bus_req), .bus_grant(bus_grant), .sel(sel),
        .Datos_I_O(Datos_I_O), .direccion_I_O(direccion_I_O),
        .MEM_RD_I_O(MEM_RD_I_O), .MEM_WR_I_O(MEM_WR_I_O),
        .mem_dato(mem_dato), .mem_ack(mem_ack),
        .io_valid(io_valid), .io_dato_in(io_dato_in), .io_ready(io_ready),
        .io_dato_out(io_dato_out), .io_wr(io_wr), .io_accept(io_accept),
        .ocupado(ocupado), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic m, input logic [31:0] a, input logic [15:0] n);
        modo = m; dir_inicio = a; cuenta = n; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        total++;
        if ({bus_req, sel, MEM_RD_I_O, MEM_WR_I_O, io_ready, io_wr, ocupado, done, err} !== 9'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000000000",
                     {bus_req, sel, MEM_RD_I_O, MEM_WR_I_O, io_ready, io_wr, ocupado, done, err});
        end
        total++;
        if ({Datos_I_O, direccion_I_O, io_dato_out} !== 96'b0) begin
            bad++;
            $display("FAIL reset_data: got %h %h %h want 0", Datos_I_O, direccion_I_O, io_dato_out);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write();
        logic [31:0] wa [8];
        logic [31:0] wd [8];
        int nwr = 0, ndone = 0, widx = 0, sel_bad = 0;
        bus_grant = 1'b0; io_valid = 1'b1; mem_ack = 1'b1;
        pulse_start(1'b0, 32'h1000, 16'd3);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (bus_req !== 1'b1 || sel !== 1'b0) begin
                bad++;
                $display("FAIL wr_req%0d: got req=%b sel=%b want req=1 sel=0", i, bus_req, sel);
            end
            step();
        end
        bus_grant = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (io_ready) begin
                io_dato_in = 32'hA000_0000 + 32'(widx);
                widx++;
            end
            if (MEM_WR_I_O) begin
                if (nwr < 8) begin wa[nwr] = direccion_I_O; wd[nwr] = Datos_I_O; end
                nwr++;
                if (!sel || MEM_RD_I_O) sel_bad++;
            end
            if (done) begin
                ndone++;
                if (sel || err || bus_req) sel_bad++;
            end
            step();
        end
        total++;
        if (nwr !== 3) begin bad++; $display("FAIL wr_count: got %0d want 3", nwr); end
        else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (wa[i] !== 32'h1000 + 32'(4 * i) || wd[i] !== 32'hA000_0000 + 32'(i)) begin
                    bad++;
                    $display("FAIL wr_word%0d: got addr=%h data=%h want addr=%h data=%h",
                             i, wa[i], wd[i], 32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
                end
            end
        end
        total++;
        if (ndone !== 1) begin bad++; $display("FAIL wr_done: got %0d pulses want 1", ndone); end
        total++;
        if (sel_bad !== 0) begin bad++; $display("FAIL wr_sel: got %0d bad cycles want 0", sel_bad); end
        total++;
        if (ocupado !== 1'b0 || sel !== 1'b0) begin
            bad++;
            $display("FAIL wr_idle: got ocupado=%b sel=%b want 0 0", ocupado, sel);
        end
    endtask

    task automatic test_read();
        logic [31:0] ra [4];
        logic [31:0] ro [4];
        logic [31:0] a0 = '0;
        int rdw = 0, iow = 0, nrd_cyc = 0, nio_cyc = 0, nack = 0, nout = 0, hold_bad = 0, ndone = 0;
        bus_grant = 1'b1; mem_ack = 1'b0; io_accept = 1'b0; io_valid = 1'b0;
        pulse_start(1'b1, 32'h2000, 16'd2);
        for (int c = 0; c < 40; c++) begin
            mem_ack = 1'b0; io_accept = 1'b0; mem_dato = 32'hDEAD_BEEF;
            if (MEM_RD_I_O) begin
                nrd_cyc++;
                if (MEM_WR_I_O || !sel) hold_bad++;
                if (rdw == 0) a0 = direccion_I_O;
                else if (direccion_I_O !== a0) hold_bad++;
                rdw++;
                if (rdw > 3) begin
                    mem_ack = 1'b1;
                    mem_dato = 32'hD000_0000 + 32'(nack);
                    if (nack < 4) ra[nack] = a0;
                    nack++;
                end
            end else rdw = 0;
            if (io_wr) begin
                nio_cyc++;
                iow++;
                if (iow > 2) begin
                    io_accept = 1'b1;
                    if (nout < 4) ro[nout] = io_dato_out;
                    nout++;
                end
            end else iow = 0;
            if (done) ndone++;
            step();
        end
        mem_ack = 1'b0; io_accept = 1'b0;
        total++;
        if (nrd_cyc !== 8 || hold_bad !== 0) begin
            bad++;
            $display("FAIL rd_hold: got strobe_cycles=%0d unstable=%0d want 8 0", nrd_cyc, hold_bad);
        end
        total++;
        if (nio_cyc !== 6) begin bad++; $display("FAIL rd_iowr: got %0d cycles want 6", nio_cyc); end
        total++;
        if (nout !== 2 || nack !== 2) begin
            bad++;
            $display("FAIL rd_count: got out=%0d ack=%0d want 2 2", nout, nack);
        end else begin
            for (int i = 0; i < 2; i++) begin
                total++;
                if (ra[i] !== 32'h2000 + 32'(4 * i) || ro[i] !== 32'hD000_0000 + 32'(i)) begin
                    bad++;
                    $display("FAIL rd_word%0d: got addr=%h out=%h want addr=%h out=%h",
                             i, ra[i], ro[i], 32'h2000 + 32'(4 * i), 32'hD000_0000 + 32'(i));
                end
            end
        end
        total++;
        if (ndone !== 1) begin bad++; $display("FAIL rd_done: got %0d pulses want 1", ndone); end
    endtask

    task automatic test_zero();
        bus_grant = 1'b1;
        pulse_start(1'b0, 32'h5000, 16'd0);
        total++;
        if ({done, sel, bus_req, ocupado} !== 4'b1001) begin
            bad++;
            $display("FAIL zero_release: got done/sel/req/ocupado=%b want 1001", {done, sel, bus_req, ocupado});
        end
        step();
        total++;
        if ({done, sel, bus_req, ocupado} !== 4'b0000) begin
            bad++;
            $display("FAIL zero_idle: got done/sel/req/ocupado=%b want 0000", {done, sel, bus_req, ocupado});
        end
    endtask

    task automatic test_wrap();
        logic [31:0] wa [4];
        int nwr = 0;
        bus_grant = 1'b1; mem_ack = 1'b1; io_valid = 1'b1;
        pulse_start(1'b0, 32'hFFFF_FFFC, 16'd2);
        for (int c = 0; c < 15; c++) begin
            if (MEM_WR_I_O) begin
                if (nwr < 4) wa[nwr] = direccion_I_O;
                nwr++;
            end
            step();
        end
        total++;
        if (nwr !== 2) begin bad++; $display("FAIL wrap_count: got %0d want 2", nwr); end
        else begin
            total++;
            if (wa[0] !== 32'hFFFF_FFFC || wa[1] !== 32'h0000_0000) begin
                bad++;
                $display("FAIL wrap_addr: got %h %h want fffffffc 00000000", wa[0], wa[1]);
            end
        end
    endtask

    task automatic test_grant_loss();
        logic [31:0] wa [4];
        int nwr = 0;
        bus_grant = 1'b1; mem_ack = 1'b1; io_valid = 1'b1;
        pulse_start(1'b0, 32'h3000, 16'd5);
        for (int c = 0; c < 20; c++) begin
            // A start mid-transfer with different parameters must be ignored.
            start = (c == 1);
            dir_inicio = 32'h9000; cuenta = 16'd1; modo = 1'b1;
            if (MEM_WR_I_O) begin
                if (nwr < 4) wa[nwr] = direccion_I_O;
                nwr++;
                if (nwr == 2) break;
            end
            step();
        end
        start = 1'b0;
        total++;
        if (nwr !== 2) begin
            bad++;
            $display("FAIL gl_reach: got %0d writes want 2", nwr);
        end else begin
            total++;
            if (wa[1] !== 32'h3004) begin
                bad++;
                $display("FAIL gl_start_ignored: got addr=%h want 00003004", wa[1]);
            end
            bus_grant = 1'b0; mem_ack = 1'b0;
            step();
            total++;
            if ({MEM_WR_I_O, MEM_RD_I_O, err, done, bus_req, sel} !== 6'b001100) begin
                bad++;
                $display("FAIL gl_abort: got wr/rd/err/done/req/sel=%b want 001100",
                         {MEM_WR_I_O, MEM_RD_I_O, err, done, bus_req, sel});
            end
            step();
            total++;
            if ({done, ocupado, err} !== 3'b001) begin
                bad++;
                $display("FAIL gl_after: got done/ocupado/err=%b want 001", {done, ocupado, err});
            end
        end
        bus_grant = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] wa [4];
        int nwr = 0, ndone = 0;
        bus_grant = 1'b1; mem_ack = 1'b1; io_valid = 1'b1;
        pulse_start(1'b0, 32'h6000, 16'd4);
        for (int c = 0; c < 20; c++) begin
            if (MEM_WR_I_O) begin
                nwr++;
                if (nwr == 3) begin mem_ack = 1'b0; break; end
            end
            step();
        end
        total++;
        if (nwr !== 3) begin bad++; $display("FAIL rm_reach: got %0d writes want 3", nwr); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus_req, sel, MEM_RD_I_O, MEM_WR_I_O, io_ready, io_wr, ocupado, done, err} !== 9'b0 ||
            {Datos_I_O, direccion_I_O, io_dato_out} !== 96'b0) begin
            bad++;
            $display("FAIL rm_outputs: got ctrl=%b addr=%h data=%h want 0",
                     {bus_req, sel, MEM_RD_I_O, MEM_WR_I_O, io_ready, io_wr, ocupado, done, err},
                     direccion_I_O, Datos_I_O);
        end
        step();
        total++;
        if (done !== 1'b0 || ocupado !== 1'b0) begin
            bad++;
            $display("FAIL rm_nodone: got done=%b ocupado=%b want 0 0", done, ocupado);
        end
        rst_n = 1'b1;
        step();
        mem_ack = 1'b1;
        pulse_start(1'b0, 32'h7000, 16'd1);
        nwr = 0;
        for (int c = 0; c < 10; c++) begin
            if (MEM_WR_I_O) begin
                if (nwr < 4) wa[nwr] = direccion_I_O;
                nwr++;
            end
            if (done) begin
                ndone++;
                total++;
                if (err !== 1'b0) begin bad++; $display("FAIL rm_err: got %b want 0", err); end
            end
            step();
        end
        total++;
        if (nwr !== 1 || ndone !== 1) begin
            bad++;
            $display("FAIL rm_rerun: got writes=%0d done=%0d want 1 1", nwr, ndone);
        end else begin
            total++;
            if (wa[0] !== 32'h7000) begin
                bad++;
                $display("FAIL rm_addr: got %h want 00007000", wa[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_zero();
        test_wrap();
        test_grant_loss();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_control.md
Name: dma_control

Overview:
- DMA engine that moves a block of 32-bit words between an I/O peripheral and main memory.
- Sits directly upstream of the memory-bus master multiplexer. Drives its select line plus the I/O-side data, address and MEM_RD/MEM_WR inputs.
- Requests the bus from the CPU, takes ownership once granted, runs the block transfer word by word, then returns the bus to the CPU.

Parameters:
- ADDR_STEP, 4, byte increment applied to the memory address after each word.
- CNT_W, 16, width of the word-count register.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse from CPU; latches dir_inicio, cuenta and modo.
- modo  in  1  0 = I/O to memory (write), 1 = memory to I/O (read).
- dir_inicio  in  32  first memory byte address.
- cuenta  in  CNT_W  number of words to move.
- bus_req  out  1  bus request to CPU.
- bus_grant  in  1  bus grant from CPU.
- sel  out  1  mux select; 1 = DMA owns the bus.
- Datos_I_O  out  32  write data to the memory bus.
- direccion_I_O  out  32  memory address.
- MEM_RD_I_O  out  1  memory read strobe.
- MEM_WR_I_O  out  1  memory write strobe.
- mem_dato  in  32  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completes the current access.
- io_valid  in  1  peripheral presents io_dato_in (write mode).
- io_dato_in  in  32  peripheral data.
- io_ready  out  1  DMA accepts io_dato_in this cycle.
- io_dato_out  out  32  data to peripheral (read mode).
- io_wr  out  1  io_dato_out valid.
- io_accept  in  1  peripheral takes io_dato_out.
- ocupado  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  set on grant loss; cleared by the next accepted start.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; internal address/count registers 0. Reset mid-transfer abandons it immediately; no done pulse.
- States: IDLE, REQ, IO_IN, MEM_ACC, IO_OUT, RELEASE.
- IDLE:
  - start=1 latches the inputs, clears err, sets ocupado=1 next cycle.
  - cuenta=0 -> RELEASE directly, with no bus_req.
  - Otherwise -> REQ.
- REQ: bus_req=1; hold until bus_grant=1. Then go to IO_IN (modo=0) or MEM_ACC (modo=1); sel=1 from that next state onward.
- IO_IN (modo=0): io_ready=1. When io_valid=1, register io_dato_in into Datos_I_O -> MEM_ACC.
- MEM_ACC:
  - Drives direccion_I_O = current address; MEM_WR_I_O=1 (modo=0) or MEM_RD_I_O=1 (modo=1).
  - Holds strobe, address and data stable until mem_ack=1.
  - On mem_ack: address += ADDR_STEP (mod 2^32 wrap); remaining -= 1.
  - modo=1: register mem_dato into io_dato_out -> IO_OUT.
  - modo=0: remaining becomes 0 -> RELEASE, else -> IO_IN.
- IO_OUT: io_wr=1; hold until io_accept=1. Then remaining=0 -> RELEASE, else -> MEM_ACC.
- Strobes are single-word: MEM_RD_I_O and MEM_WR_I_O are never both 1. Both are 0 in every state except MEM_ACC.
- RELEASE (1 cycle): sel=0, bus_req=0, strobes 0, done=1, ocupado=0 next cycle -> IDLE.
- Grant loss: bus_grant=0 while sel=1 aborts the transfer. Strobes drop next cycle, err=1, -> RELEASE; done still pulses.
- start while ocupado=1 is ignored; latched registers are unchanged.
- Latency for modo=1 with zero-wait memory and peripheral: 2 cycles per word after grant, plus 1 RELEASE cycle.

Test Plan:
- Reset mid-MEM_ACC (modo=0, cuenta=4, after word 2) -> all outputs 0 within the reset cycle; no done; a new start runs cleanly.
- modo=0, dir_inicio=0x1000, cuenta=3, grant after 2 cycles, io_valid always 1, mem_ack immediate:
  - writes io words to 0x1000, 0x1004, 0x1008 with MEM_WR_I_O=1.
  - sel=1 only between grant and RELEASE; done pulses once; err=0.
- modo=1, dir_inicio=0x2000, cuenta=2, mem_ack delayed 3 cycles, io_accept delayed 2:
  - MEM_RD_I_O and direccion_I_O held stable through the waits.
  - io_dato_out equals mem_dato per word; total 2 words.
- cuenta=0 start -> no bus_req, done pulses 1 cycle after the IDLE start, sel stays 0.
- dir_inicio=0xFFFFFFFC, cuenta=2, modo=0 -> second address is 0x00000000.
- Grant dropped during word 2 of cuenta=5 -> strobes off next cycle, err=1, done=1, bus_req=0. A start pulse during the transfer has no effect.
